hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 RsD, RtD, RsE, RtE  in  5 each  source register indices in Decode/Execute.
REQ-005 WriteRegE, WriteRegM, WriteRegW  in  5 each  destination indices; RegWriteE/M/W  in  1 each  write enables.
REQ-006 MemtoRegE, MemtoRegM  in  1 each  load in stage; BranchD, JumpRegD  in  1 each  Decode consumes registers early.
REQ-007 MemReqM  in  1  data request in Memory; DataOkM  in  1  data response valid.
REQ-008 MulDivStartE, MulDivIsDivE  in  1 each  multi-cycle op in Execute; divide when IsDiv=1.
REQ-009 StallF, StallD, StallE, StallM, FlushE, FlushM  out  1 each  pipeline register control.
REQ-010 ForwardAD, ForwardBD  out  1 each; ForwardAE, ForwardBE  out  2 each; MulDivBusy, MulDivDone  out  1 each.

Function
REQ-011 Match(x,r) SHALL mean r!=0 and x==r; register 0 never matches.
REQ-012 ForwardAE SHALL be 2'b10 if RegWriteM and Match(RsE,WriteRegM), else 2'b01 if RegWriteW and Match(RsE,WriteRegW), else 2'b00; ForwardBE likewise with RtE.
REQ-013 ForwardAD SHALL be RegWriteM and Match(RsD,WriteRegM); ForwardBD likewise with RtD.
REQ-014 Load-use (LU) SHALL be MemtoRegE and (Match(RsD,WriteRegE) or Match(RtD,WriteRegE)).
REQ-015 Branch hazard (BH) SHALL be (BranchD or JumpRegD) and ((RegWriteE and Match(RsD|RtD,WriteRegE)) or (MemtoRegM and Match(RsD|RtD,WriteRegM))).
REQ-016 Memory wait (MW) SHALL be MemReqM and not DataOkM.
REQ-017 MulDiv FSM states SHALL be IDLE, BUSY; counter cnt 5 bits.
REQ-018 Accept SHALL be IDLE and MulDivStartE and not MW; on accept, cnt<=LAT-1 (LAT=4 mult, 32 div), state<=BUSY.
REQ-019 In BUSY with cnt!=0, cnt SHALL decrement every cycle regardless of MW.
REQ-020 In BUSY with cnt==0, MulDivDone SHALL be 1; state SHALL return to IDLE only on a cycle without MW, else hold.
REQ-021 MD (muldiv stall) SHALL be (IDLE and MulDivStartE) or (BUSY and cnt!=0); MulDivBusy = BUSY.
REQ-022 StallM SHALL equal MW; StallE SHALL be MW or MD.
REQ-023 StallF and StallD SHALL be MW or MD or LU or BH.
REQ-024 FlushE SHALL be (LU or BH) and not MW and not MD; the instruction held in Execute is never flushed.
REQ-025 FlushM SHALL be MD and not MW (bubble into Memory while Execute holds).
REQ-026 All outputs except MulDivBusy/MulDivDone SHALL be combinational from inputs and state; no added latency.
REQ-027 MulDivStartE asserted while BUSY SHALL be ignored.

Reset
REQ-028 resetn low SHALL force state IDLE, cnt 0, immediately and asynchronously.
REQ-029 Reset mid-operation SHALL abandon the op; MulDivBusy and MulDivDone 0 while reset asserted and after release until a new accept.
REQ-030 With all inputs 0 after reset, every output SHALL be 0.

Configuration
REQ-031 Macro HAZARD_MULDIV_EN SHALL gate the multi-cycle unit tracking.
REQ-032 Defined: REQ-017 to REQ-021, REQ-025, REQ-027 apply.
REQ-033 Undefined: no FSM/counter; MD, FlushM, MulDivBusy, MulDivDone tie 0; MulDivStartE/IsDivE ignored.

Verification
REQ-034 RegWriteM=1, WriteRegM=8, RsE=8, RegWriteW=1, WriteRegW=8 -> ForwardAE=2'b10; WriteRegM=0, RsE=0 -> 2'b00.
REQ-035 MemtoRegE=1, WriteRegE=5, RtD=5 -> StallF=StallD=FlushE=1, StallE=0; same with MemReqM=1, DataOkM=0 -> FlushE=0, StallE=StallM=1.
REQ-036 MulDivStartE=1, IsDiv=0 from IDLE -> StallE=1 for exactly 4 cycles, FlushM=1 those cycles, MulDivDone=1 in 5th, StallE=0 there.
REQ-037 Div start, MW asserted cycles 10-40 -> cnt still reaches 0 at 32 cycles; FSM stays BUSY with Done=1 until MW drops, then IDLE.
REQ-038 resetn low at div cycle 12 -> MulDivBusy=0 immediately, no stall after release with MulDivStartE=0.
REQ-039 HAZARD_MULDIV_EN undefined, MulDivStartE=1 -> StallE=0, FlushM=0, MulDivBusy=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a five-stage core.
// It produces the forwarding selects, the stall and flush controls, and it
// tracks a multi-cycle multiply/divide unit.
//
// Compile-time option:
//   HAZARD_MULDIV_EN  When this is defined, the block tracks the multiply/divide
//                     unit (an IDLE/BUSY FSM plus a 5-bit countdown).
//                     When it is undefined, the muldiv stall, FlushM,
//                     MulDivBusy and MulDivDone are all tied low, and the
//                     MulDivStartE and MulDivIsDivE inputs are ignored.
//
// Handshake: MemReqM is a data request in Memory. It completes in the cycle
// in which DataOkM is high. While MemReqM=1 and DataOkM=0 the memory stage
// waits, and every stage at or upstream of Memory holds.
//
// Every output except MulDivBusy/MulDivDone is combinational from the
// current inputs and the state, so no extra cycle of latency is added.
// MulDivBusy exposes the FSM state directly.
module hazard_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       JumpRegD,
    input  logic       MemReqM,
    input  logic       DataOkM,
    input  logic       MulDivStartE,
    input  logic       MulDivIsDivE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushE,
    output logic       FlushM,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MulDivBusy,
    output logic       MulDivDone
);

    // Register 0 is hard-wired to zero, so a write to it never matches.
    function automatic logic reg_match(input logic [4:0] x, input logic [4:0] r);
        return (r != 5'd0) && (x == r);
    endfunction

    logic lu;   // load-use hazard between Execute and Decode
    logic bh;   // Decode branch/jump-register needs a value not yet available
    logic mw;   // memory stage waiting for its data response
    logic md;   // multiply/divide unit holds Execute

    // Forwarding selects: the value in Memory is newer, so it wins over Writeback.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && reg_match(RsE, WriteRegM))      ForwardAE = 2'b10;
        else if (RegWriteW && reg_match(RsE, WriteRegW)) ForwardAE = 2'b01;
        if (RegWriteM && reg_match(RtE, WriteRegM))      ForwardBE = 2'b10;
        else if (RegWriteW && reg_match(RtE, WriteRegW)) ForwardBE = 2'b01;
    end

    assign ForwardAD = RegWriteM && reg_match(RsD, WriteRegM);
    assign ForwardBD = RegWriteM && reg_match(RtD, WriteRegM);

    assign lu = MemtoRegE && (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE));

    assign bh = (BranchD || JumpRegD) &&
                ((RegWriteE && (reg_match(RsD, WriteRegE) || reg_match(RtD, WriteRegE))) ||
                 (MemtoRegM && (reg_match(RsD, WriteRegM) || reg_match(RtD, WriteRegM))));

    assign mw = MemReqM && !DataOkM;

`ifdef HAZARD_MULDIV_EN
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    // The countdown is loaded with latency-1, so Done appears in the cycle
    // after the last stalled cycle.
    localparam logic [4:0] MUL_LAST = 5'd3;
    localparam logic [4:0] DIV_LAST = 5'd31;

    md_state_t  state;
    logic [4:0] cnt;

    // MulDiv FSM. An accept is blocked by a memory wait, because Execute
    // cannot hand off while it is held. Once the op is running, the count
    // keeps going during memory waits. The FSM leaves BUSY only when the
    // pipeline can move.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (MulDivStartE && !mw) begin
                        cnt   <= MulDivIsDivE ? DIV_LAST : MUL_LAST;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 5'd0) cnt   <= cnt - 5'd1;
                    else if (!mw)    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

    assign md         = ((state == IDLE) && MulDivStartE) || ((state == BUSY) && (cnt != 5'd0));
    assign MulDivBusy = (state == BUSY);
    assign MulDivDone = (state == BUSY) && (cnt == 5'd0);
    assign FlushM     = md && !mw;
`else
    logic unused_muldiv;
    assign unused_muldiv = ^{clk, resetn, MulDivStartE, MulDivIsDivE};

    assign md         = 1'b0;
    assign MulDivBusy = 1'b0;
    assign MulDivDone = 1'b0;
    assign FlushM     = 1'b0;
`endif

    // Stall and flush controls. The instruction held in Execute is never
    // flushed. A bubble goes into Memory while Execute waits on muldiv.
    assign StallM = mw;
    assign StallE = mw || md;
    assign StallD = mw || md || lu || bh;
    assign StallF = mw || md || lu || bh;
    assign FlushE = (lu || bh) && !mw && !md;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl.
// It runs directed scenarios first and then random cycles. Every output is
// checked against a behavioural model that is written from the hazard
// rules. The model follows the muldiv unit as "cycles since accept" against
// the op latency.
module tb_hazard_ctrl;

  logic       clk;
  logic       resetn;
  logic [4:0] RsD, RtD, RsE, RtE;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM, BranchD, JumpRegD;
  logic       MemReqM, DataOkM, MulDivStartE, MulDivIsDivE;
  logic       StallF, StallD, StallE, StallM, FlushE, FlushM;
  logic       ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MulDivBusy, MulDivDone;

  int errors = 0;
  int checks = 0;

  // muldiv model state
  bit m_active;
  int m_elapsed;
  int m_lat;

  // most recent observed values, used by the directed timing checks
  logic obs_stall_e, obs_done, obs_busy, obs_flush_m;

  hazard_ctrl dut (
    .clk(clk), .resetn(resetn),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpRegD(JumpRegD),
    .MemReqM(MemReqM), .DataOkM(DataOkM),
    .MulDivStartE(MulDivStartE), .MulDivIsDivE(MulDivIsDivE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit hit(int x, int r);
    return (r != 0) && (x == r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 1'b0;
    m_elapsed = 0;
    m_lat     = 0;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_all(input string tag);
    bit mw_e, lu_e, bh_e, md_e, done_e, busy_e;
    int fae, fbe;
    mw_e = MemReqM && !DataOkM;
    lu_e = MemtoRegE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE));
    bh_e = (BranchD || JumpRegD) &&
           ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
            (MemtoRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
`ifdef HAZARD_MULDIV_EN
    md_e   = (!m_active && MulDivStartE) || (m_active && m_elapsed < m_lat);
    done_e = m_active && m_elapsed >= m_lat;
    busy_e = m_active;
`else
    md_e   = 1'b0;
    done_e = 1'b0;
    busy_e = 1'b0;
`endif
    fae = (RegWriteM && hit(RsE, WriteRegM)) ? 2 : (RegWriteW && hit(RsE, WriteRegW)) ? 1 : 0;
    fbe = (RegWriteM && hit(RtE, WriteRegM)) ? 2 : (RegWriteW && hit(RtE, WriteRegW)) ? 1 : 0;
    check({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(fae));
    check({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(fbe));
    check({tag, ".ForwardAD"}, 32'(ForwardAD), 32'(RegWriteM && hit(RsD, WriteRegM)));
    check({tag, ".ForwardBD"}, 32'(ForwardBD), 32'(RegWriteM && hit(RtD, WriteRegM)));
    check({tag, ".StallF"}, 32'(StallF), 32'(mw_e || md_e || lu_e || bh_e));
    check({tag, ".StallD"}, 32'(StallD), 32'(mw_e || md_e || lu_e || bh_e));
    check({tag, ".StallE"}, 32'(StallE), 32'(mw_e || md_e));
    check({tag, ".StallM"}, 32'(StallM), 32'(mw_e));
    check({tag, ".FlushE"}, 32'(FlushE), 32'((lu_e || bh_e) && !mw_e && !md_e));
    check({tag, ".FlushM"}, 32'(FlushM), 32'(md_e && !mw_e));
    check({tag, ".MulDivBusy"}, 32'(MulDivBusy), 32'(busy_e));
    check({tag, ".MulDivDone"}, 32'(MulDivDone), 32'(done_e));
    obs_stall_e = StallE;
    obs_done    = MulDivDone;
    obs_busy    = MulDivBusy;
    obs_flush_m = FlushM;
  endtask

  // Advance the muldiv model by one rising edge.
  task automatic model_update();
`ifdef HAZARD_MULDIV_EN
    bit mw_e;
    mw_e = MemReqM && !DataOkM;
    if (!resetn) model_reset();
    else if (!m_active) begin
      if (MulDivStartE && !mw_e) begin
        m_active  = 1'b1;
        m_lat     = MulDivIsDivE ? 32 : 4;
        m_elapsed = 1;
      end
    end else if (m_elapsed < m_lat) m_elapsed++;
    else if (!mw_e) model_reset();
`endif
  endtask

  // Inputs are set at the negedge. Outputs are checked 2 time units later,
  // and then the model steps at the posedge.
  task automatic run_cycle(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, JumpRegD} = '0;
    {MemReqM, DataOkM, MulDivStartE, MulDivIsDivE} = '0;
  endtask

  initial begin
    int first_done;
    int last_busy;
    int n_stall;
    clear_inputs();
    model_reset();
    resetn = 1'b0;

    // reset: with all inputs at zero, every output is zero
    @(negedge clk);
    run_cycle("reset");
    resetn = 1'b1;
    run_cycle("idle_zero");

    // forwarding priority: Memory wins over Writeback; register 0 never matches
    RegWriteM = 1; WriteRegM = 8; RsE = 8; RegWriteW = 1; WriteRegW = 8;
    run_cycle("fwd_prio");
    check("fwd_prio_ae", 32'(ForwardAE), 32'd2);
    WriteRegM = 0; RsE = 0; WriteRegW = 0;
    run_cycle("fwd_r0");
    clear_inputs();

    // load-use: without a memory wait, then with one
    MemtoRegE = 1; WriteRegE = 5; RtD = 5;
    run_cycle("load_use");
    MemReqM = 1; DataOkM = 0;
    run_cycle("load_use_mw");
    clear_inputs();

    // branch hazard on a value produced in Execute and on a load in Memory
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    run_cycle("branch_e");
    clear_inputs();
    JumpRegD = 1; RtD = 7; MemtoRegM = 1; WriteRegM = 7;
    run_cycle("jr_m");
    clear_inputs();

`ifdef HAZARD_MULDIV_EN
    // multiply: 4 stalled cycles, then Done in the 5th
    n_stall = 0; first_done = -1;
    for (int i = 0; i < 7; i++) begin
      MulDivStartE = (i == 0);
      run_cycle("mult");
      if (obs_stall_e) n_stall++;
      if (obs_done && first_done < 0) first_done = i;
    end
    check("mult_stall_cycles", 32'(n_stall), 32'd4);
    check("mult_done_cycle", 32'(first_done), 32'd4);

    // divide with a memory wait in cycles 10-40: Done at 32, held until the wait drops
    first_done = -1; last_busy = -1;
    for (int i = 0; i < 45; i++) begin
      MulDivStartE = (i == 0); MulDivIsDivE = (i == 0);
      MemReqM = (i >= 10 && i <= 40);
      run_cycle("div_mw");
      if (obs_done && first_done < 0) first_done = i;
      if (obs_busy) last_busy = i;
    end
    check("div_done_cycle", 32'(first_done), 32'd32);
    check("div_last_busy", 32'(last_busy), 32'd41);
    clear_inputs();

    // reset in the middle of a divide abandons the op at once
    for (int i = 0; i < 12; i++) begin
      MulDivStartE = (i == 0); MulDivIsDivE = (i == 0);
      run_cycle("div_pre_rst");
    end
    clear_inputs();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("rst_busy_async", 32'(MulDivBusy), 32'd0);
    @(negedge clk);
    run_cycle("in_rst");
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle("post_rst");
      check("post_rst_stall_e", 32'(obs_stall_e), 32'd0);
    end
`else
    // without the muldiv option, a start request has no effect
    MulDivStartE = 1; MulDivIsDivE = 1;
    for (int i = 0; i < 3; i++) begin
      run_cycle("muldiv_off");
      check("off_stall_e", 32'(obs_stall_e), 32'd0);
      check("off_flush_m", 32'(obs_flush_m), 32'd0);
    end
    clear_inputs();
`endif

    // random traffic; small register indices so that matches are common
    for (int i = 0; i < 400; i++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
      MemtoRegM = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
      JumpRegD = 1'($urandom_range(0, 1)); MemReqM = 1'($urandom_range(0, 1));
      DataOkM = 1'($urandom_range(0, 1));
      MulDivStartE = ($urandom_range(0, 5) == 0); MulDivIsDivE = 1'($urandom_range(0, 1));
      run_cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
